rotation_tracker: RTL
=====================

# rotation_tracker

Converts the raw IR beam-break input from the spinning POV assembly into a registered angular slice index (`dtheta`) for `frame_manager`. Synchronizes and debounces the IR input, measures the rotation period in clock cycles, and steps `dtheta` through `ROTATIONAL_RES` equal slices per revolution using the previous revolution's period. Provides lock and stall status so downstream stages blank the panel when the rotor is stopped or unstable.

## Interface
- `ROTATIONAL_RES`, 1024, slices per revolution; power of two, ≥2
- `PERIOD_WIDTH`, 24, width of the period counter (2^24 cycles ≈ 0.7 s at 24 MHz)
- `DEBOUNCE_CYCLES`, 240, consecutive stable cycles required before the debounced level changes
- `MIN_PERIOD`, 4096, shortest accepted revolution in cycles; shorter index events are glitches
- `MAX_PERIOD`, 2^24-1, timeout; counter reaching it drops lock

Ports:
- `clk_in`  in  1  system clock (`sysclk`, 24 MHz)
- `rst_in`  in  1  synchronous, active-high reset
- `ir_tripped`  in  1  asynchronous IR sensor level, high while the beam is broken
- `dtheta`  out  $clog2(ROTATIONAL_RES)  current angular slice
- `theta_strobe`  out  1  one-cycle pulse when `dtheta` takes a new value (including the return to 0)
- `locked`  out  1  high while the period is valid and slices are being generated
- `period_cycles`  out  PERIOD_WIDTH  last accepted revolution length in cycles

## Operation
- Sync: 2-FF synchronizer on `ir_tripped`.
- Debounce: the debounced level takes the synced value after it has differed from the current level for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle clears the run counter.
- Index event: rising edge of the debounced level.
- Period counter `cnt`: increments every cycle and saturates at `MAX_PERIOD`. A valid index sets it to 1, so at an index N cycles after the previous one, `cnt` = N.
- Valid index: `cnt ≥ MIN_PERIOD`, or state is IDLE. An invalid index is ignored entirely: no effect on `cnt` or `dtheta`.
- `slice_len` = `period_cycles >> log2(ROTATIONAL_RES)`, floored at 1. The slice counter counts 0..`slice_len`-1. At terminal count, `dtheta` increments and saturates at `ROTATIONAL_RES`-1; it never wraps without an index.
- States (typedef in package):
  - IDLE: `dtheta`=0, `locked`=0. Valid index → ACQUIRE, `cnt`←1.
  - ACQUIRE: valid index with `cnt` < `MAX_PERIOD` → LOCKED, `period_cycles`←`cnt`, `dtheta`←0, slice counter←0, strobe.
  - LOCKED: valid index → `period_cycles`←`cnt`, `dtheta`←0, slice counter←0, strobe. Slice terminal count with `dtheta` < RES-1 → increment, strobe.
  - Any state: `cnt` = `MAX_PERIOD` → IDLE, `dtheta`←0, `locked`←0. `period_cycles` is retained.
- Simultaneous index and slice terminal count: the index wins (`dtheta`←0).
- Simultaneous index and timeout: the timeout wins.
- `theta_strobe` is asserted only in LOCKED (including the ACQUIRE→LOCKED transition cycle). An index when `dtheta` is already 0 still pulses.
- `rst_in` at any time clears all state next edge. Reset values: `dtheta`=0, `theta_strobe`=0, `locked`=0, `period_cycles`=0, state IDLE.

## Timing
- `ir_tripped` rise to index event: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle.
- Index event to registered `dtheta`/`theta_strobe`/`locked` update: 1 cycle. Strobe and new `dtheta` are visible in the same cycle.
- `locked` rises with the first strobe and falls in the cycle after `cnt` reaches `MAX_PERIOD`.
- `slice_len` is recomputed from the registered `period_cycles`. The new value takes effect from slice 0 of the revolution following the index.
- No divider: shift only. Steady state: one `dtheta` step per `slice_len` cycles. Residual cycles (`period mod RES`) accumulate as extra dwell at slice RES-1.

## Structure
- Package `pov_pkg` holds:
  - the `rot_state_t` enum (IDLE/ACQUIRE/LOCKED)
  - `ROTATIONAL_RES`
  - `THETA_WIDTH` = $clog2(ROTATIONAL_RES)
  - these are shared with `frame_manager`
- Sub-module `ir_debouncer` (clk_in, rst_in, raw in, level out, rise out) contains the synchronizer, debounce counter, and edge detect.
- The top module contains the period counter, FSM, slice counter, and outputs.

## Test plan
Bench parameters: RES=16, DEBOUNCE=4, MIN=64, PERIOD_WIDTH=16, MAX=4000.
- Reset: hold `rst_in` 3 cycles, toggle `ir_tripped` during it → all outputs 0, IDLE.
- Steady spin: clean rises 1600 cycles apart → after 2nd rise `locked`=1, `period_cycles`=1600. `dtheta` steps 0..15 every 100 cycles with 16 strobes per rev, returning to 0 on each index.
- Bounce: 3-cycle high glitches between real edges → no index, no extra strobes. A 20-cycle pulse 30 cycles after an index (<MIN) → ignored, `cnt` continues.
- Speed-up: period drops 1600→800 → `dtheta` reaches only 7 before the index resets it to 0. The next rev steps every 50 cycles.
- Slow-down: period 1600→2400 → `dtheta` saturates at 15 for 800 cycles without wrapping, then 0 on index.
- Stall: stop edges after lock → `locked` falls when `cnt` hits 4000, `dtheta`=0, no strobes. Resuming requires two indices to relock. A mid-rev `rst_in` pulse → immediate IDLE.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared POV display definitions: angular resolution and rotation tracker states.
package pov_pkg;

    localparam int unsigned ROTATIONAL_RES = 1024;
    localparam int unsigned THETA_WIDTH    = $clog2(ROTATIONAL_RES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } rot_state_t;

endpackage

// File: rtl/ir_debouncer.sv
// IR beam-break conditioning: 2-FF synchronizer, run-length debounce and a
// registered one-cycle pulse on the rising edge of the debounced level.
module ir_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 240
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_RUN_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_run;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_run     <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
            if (r_sync2 != r_level) begin
                if (r_run == C_RUN_LAST) begin
                    r_level <= r_sync2;
                    r_run   <= '0;
                end else begin
                    r_run <= r_run + CW'(1);
                end
            end else begin
                r_run <= '0;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/rotation_tracker.sv
// Turns debounced IR index events into a per-revolution period measurement and
// a registered angular slice index stepped at period/ROTATIONAL_RES cycles.
module rotation_tracker #(
    parameter int unsigned ROTATIONAL_RES  = pov_pkg::ROTATIONAL_RES,
    parameter int unsigned PERIOD_WIDTH    = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 240,
    parameter int unsigned MIN_PERIOD      = 4096,
    parameter int unsigned MAX_PERIOD      = (2 ** 24) - 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              theta_strobe,
    output logic                              locked,
    output logic [PERIOD_WIDTH-1:0]           period_cycles
);

    import pov_pkg::*;

    localparam int unsigned               C_THETA_W   = $clog2(ROTATIONAL_RES);
    localparam logic [C_THETA_W-1:0]      C_THETA_MAX = C_THETA_W'(ROTATIONAL_RES - 1);
    localparam logic [PERIOD_WIDTH-1:0]   C_MAX       = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0]   C_MIN       = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0]   C_ONE       = PERIOD_WIDTH'(1);

    rot_state_t            r_state;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_slice;
    logic [C_THETA_W-1:0]    r_dtheta;
    logic                    r_strobe;

    logic                    w_ir_level_unused;
    logic                    w_ir_rise;
    logic                    w_cnt_max;
    logic                    w_timeout;
    logic                    w_valid_idx;
    logic [PERIOD_WIDTH-1:0] w_shift;
    logic [PERIOD_WIDTH-1:0] w_slice_len;
    logic                    w_slice_last;

    ir_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .raw    (ir_tripped),
        .level  (w_ir_level_unused),
        .rise   (w_ir_rise)
    );

    assign w_cnt_max    = (r_cnt == C_MAX);
    // Timeout only matters once a revolution is being tracked; IDLE must still accept an index.
    assign w_timeout    = w_cnt_max && (r_state != ST_IDLE);
    assign w_valid_idx  = w_ir_rise && ((r_state == ST_IDLE) || (r_cnt >= C_MIN));
    assign w_shift      = r_period >> C_THETA_W;
    assign w_slice_len  = (w_shift == '0) ? C_ONE : w_shift;
    assign w_slice_last = (r_slice == (w_slice_len - C_ONE));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_slice  <= '0;
            r_dtheta <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (!w_cnt_max) begin
                r_cnt <= r_cnt + C_ONE;
            end

            if (w_timeout) begin
                r_state  <= ST_IDLE;
                r_dtheta <= '0;
                r_slice  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_valid_idx) begin
                            r_state <= ST_ACQUIRE;
                            r_cnt   <= C_ONE;
                        end
                    end
                    ST_ACQUIRE, ST_LOCKED: begin
                        if (w_valid_idx) begin
                            r_state  <= ST_LOCKED;
                            r_cnt    <= C_ONE;
                            r_period <= r_cnt;
                            r_dtheta <= '0;
                            r_slice  <= '0;
                            r_strobe <= 1'b1;
                        end else if (r_state == ST_LOCKED) begin
                            // Residual cycles of the revolution dwell at the last slice.
                            if (w_slice_last) begin
                                r_slice <= '0;
                                if (r_dtheta != C_THETA_MAX) begin
                                    r_dtheta <= r_dtheta + C_THETA_W'(1);
                                    r_strobe <= 1'b1;
                                end
                            end else begin
                                r_slice <= r_slice + C_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dtheta        = r_dtheta;
    assign theta_strobe  = r_strobe;
    assign locked        = (r_state == ST_LOCKED);
    assign period_cycles = r_period;

endmodule
